shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/shift_add_mult_if.sv | 16 +
 rtl/shift_add_mult.sv | 121 ++++++++++++
 tb/tb_shift_add_mult.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_if.sv
// Operand/result bundle for shift_add_mult: master drives a request, slave returns status and product.
interface shift_add_mult_if #(
  parameter int WIDTH = 6
);
  // start is a single-cycle request sampled only while the multiplier is idle;
  // busy/done report progress and product holds the last completed result.
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, WIDTH cycles per product.
// Define SHIFT_ADD_MULT_SIGNED_EN for two's-complement operands using radix-2 Booth recoding.
module shift_add_mult #(
  parameter int WIDTH = 6
) (
  input  logic              clk,
  input  logic              reset,
  shift_add_mult_if.slave   bus,
  output logic [1:0]        dbg_state_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2*WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;

  logic                bit_cur;
  logic [WIDTH:0]      addend;
  logic [WIDTH:0]      hi_sum;
  logic [AW-1:0]       acc_added;
  logic [AW-1:0]       acc_step;
  logic                last_bit;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic                bit_prev;
`endif

  // One iteration: add into the upper WIDTH+1 accumulator bits, then shift right.
  always_comb begin
    bit_cur = |(a_q & (WIDTH'(1) << cnt_q));
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    // {a,0} places a[i-1] at position i, giving bit -1 = 0 for the first step.
    bit_prev = |({a_q, 1'b0} & ((WIDTH+1)'(1) << cnt_q));
    case ({bit_cur, bit_prev})
      2'b10:   addend = -{b_q[WIDTH-1], b_q};
      2'b01:   addend = {b_q[WIDTH-1], b_q};
      default: addend = '0;
    endcase
`else
    addend = bit_cur ? {1'b0, b_q} : '0;
`endif
    hi_sum    = acc_q[AW-1:WIDTH] + addend;
    acc_added = {hi_sum, acc_q[WIDTH-1:0]};
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    acc_step  = {acc_added[AW-1], acc_added[AW-1:1]};
`else
    acc_step  = {1'b0, acc_added[AW-1:1]};
`endif
    last_bit  = (cnt_q == CW'(WIDTH-1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          prod_d  = acc_step[2*WIDTH-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign bus.busy    = (state_q == S_BUSY);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = prod_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: directed corner cases plus random operands against an arithmetic model.
module tb_shift_add_mult;

  localparam int W  = 6;
  localparam int PW = 2*W;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  shift_add_mult_if #(.WIDTH(W)) bus ();

  shift_add_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] last_prod;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiplication of the operands' numeric values.
  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, p;
    logic [31:0] pv;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    sx = $signed(x);
    sy = $signed(y);
`else
    sx = int'(x);
    sy = int'(y);
`endif
    p  = sx * sy;
    pv = p;
    return pv[PW-1:0];
  endfunction

  // Runs one multiply; optionally re-pulses start during BUSY and during DONE.
  task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [PW-1:0] exp, input bit repulse, input string tag);
    int dones;
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    for (int k = 0; k < W; k++) begin
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_hold"}, 32'(bus.product), 32'(last_prod));
      if (bus.done) dones++;
      if (repulse && k == 1) begin
        bus.start = 1'b1; bus.a = 6'd2; bus.b = 6'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    check({tag, "_product"}, 32'(bus.product), 32'(exp));
    if (bus.done) dones++;
    if (repulse) begin
      bus.start = 1'b1; bus.a = 6'd3; bus.b = 6'd3;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    check({tag, "_final"}, 32'(bus.product), 32'(exp));
    check({tag, "_done_count"}, 32'(dones), 32'd1);
    last_prod = exp;
  endtask

  initial begin
    int dones;
    logic [W-1:0] rx, ry;

    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    last_prod = '0;
    #7;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    do_mult(6'd5,  6'd3,  12'd15,   1'b0, "s5x3");
    do_mult(6'd61, 6'd5,  12'hFF1,  1'b0, "sm3x5");
    do_mult(6'd63, 6'd63, 12'd1,    1'b0, "sm1xm1");
    do_mult(6'd0,  6'd45, 12'd0,    1'b0, "s0x45");
    do_mult(6'd32, 6'd32, 12'd1024, 1'b0, "sm32xm32");
    do_mult(6'd32, 6'd31, 12'hC20,  1'b0, "sm32x31");
    do_mult(6'd7,  6'd9,  12'd63,   1'b1, "s7x9_restart");
`else
    do_mult(6'd5,  6'd3,  12'd15,   1'b0, "u5x3");
    do_mult(6'd63, 6'd63, 12'hF81,  1'b0, "u63x63");
    do_mult(6'd0,  6'd45, 12'd0,    1'b0, "u0x45");
    do_mult(6'd61, 6'd5,  12'd305,  1'b0, "u61x5");
    do_mult(6'd7,  6'd9,  12'd63,   1'b1, "u7x9_restart");
`endif

    // Abort a 9*9 multiply in its third busy cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 6'd9; bus.b = 6'd9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_prod = '0;
    dones = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_product_kept", 32'(bus.product), 32'd0);
    do_mult(6'd4, 6'd4, 12'd16, 1'b0, "after_abort_4x4");

    for (int i = 0; i < 16; i++) begin
      rx = W'($urandom_range(0, (1 << W) - 1));
      ry = W'($urandom_range(0, (1 << W) - 1));
      do_mult(rx, ry, model(rx, ry), (i % 4) == 3, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
